// File: rtl/im_loader.sv
// ============================================================================
// Module   : im_loader
// Purpose  : Streams 32-bit instruction words into a byte-wide, big-endian
//            instruction memory (MSB byte at the lowest address).
// Option   : IM_LOADER_READBACK_EN adds a read-back verify pass per word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_data,
  input  logic              instr_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
`ifdef IM_LOADER_READBACK_EN
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              err_mismatch,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-2:0] word_count,
  output logic              err_overflow
);

  // Low two state bits double as the byte index within the word.
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ACCEPT = 4'd1;
  localparam logic [3:0] S_DONE   = 4'd2;
  localparam logic [3:0] S_WR0    = 4'd4;
  localparam logic [3:0] S_WR1    = 4'd5;
  localparam logic [3:0] S_WR2    = 4'd6;
  localparam logic [3:0] S_WR3    = 4'd7;
`ifdef IM_LOADER_READBACK_EN
  localparam logic [3:0] S_RB0    = 4'd8;
  localparam logic [3:0] S_RB1    = 4'd9;
  localparam logic [3:0] S_RB2    = 4'd10;
  localparam logic [3:0] S_RB3    = 4'd11;
`endif

  // Pointer carries one extra bit so "one past the top" is representable.
  localparam logic [ADDR_W:0]   BASE_PTR = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0]   TOP_PTR  = (ADDR_W+1)'((2**ADDR_W) - 4);
  localparam logic [ADDR_W:0]   PTR_STEP = (ADDR_W+1)'(4);
  localparam logic [ADDR_W-2:0] CNT_ONE  = (ADDR_W-1)'(1);

  logic [3:0]        state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [31:0]       data_q, data_d;
  logic              last_q, last_d;
  logic [ADDR_W-2:0] count_q, count_d;
  logic              ovf_q, ovf_d;
`ifdef IM_LOADER_READBACK_EN
  logic              mis_q, mis_d;
  logic              in_rb;
`endif

  logic              in_wr;
  logic              word_end;
  logic [1:0]        byte_idx;
  logic [7:0]        cur_byte;
  logic [ADDR_W-1:0] byte_addr;

  assign byte_idx  = state_q[1:0];
  assign in_wr     = (state_q[3:2] == 2'b01);
  assign byte_addr = ptr_q[ADDR_W-1:0] + {{(ADDR_W-2){1'b0}}, byte_idx};
`ifdef IM_LOADER_READBACK_EN
  assign in_rb     = (state_q[3:2] == 2'b10);
`endif

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = data_q[31:24];
      2'd1:    cur_byte = data_q[23:16];
      2'd2:    cur_byte = data_q[15:8];
      default: cur_byte = data_q[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    last_d   = last_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    word_end = 1'b0;
`ifdef IM_LOADER_READBACK_EN
    mis_d    = mis_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          ptr_d   = BASE_PTR;
          count_d = '0;
          ovf_d   = 1'b0;
`ifdef IM_LOADER_READBACK_EN
          mis_d   = 1'b0;
`endif
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (instr_valid) begin
          // Never wrap: a word that would run past the top is swallowed.
          if (ptr_q > TOP_PTR) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            data_d  = instr_data;
            last_d  = instr_last;
            state_d = S_WR0;
          end
        end
      end
      S_WR0, S_WR1, S_WR2: state_d = state_q + 4'd1;
`ifdef IM_LOADER_READBACK_EN
      S_WR3: state_d = S_RB0;
      S_RB0, S_RB1, S_RB2: begin
        if (mem_rdata != cur_byte) mis_d = 1'b1;
        state_d = state_q + 4'd1;
      end
      S_RB3: begin
        if (mem_rdata != cur_byte) mis_d = 1'b1;
        word_end = 1'b1;
      end
`else
      S_WR3: word_end = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase

    if (word_end) begin
      ptr_d   = ptr_q + PTR_STEP;
      count_d = count_q + CNT_ONE;
      state_d = last_q ? S_DONE : S_ACCEPT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE_PTR;
      data_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef IM_LOADER_READBACK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
`ifdef IM_LOADER_READBACK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign instr_ready  = (state_q == S_ACCEPT);
  assign mem_we       = in_wr;
  assign mem_addr     = in_wr ? byte_addr : '0;
  assign mem_wdata    = in_wr ? cur_byte : 8'h00;
  assign done         = (state_q == S_DONE);
  assign word_count   = count_q;
  assign err_overflow = ovf_q;
`ifdef IM_LOADER_READBACK_EN
  assign busy         = (state_q == S_ACCEPT) | in_wr | in_rb;
  assign mem_raddr    = in_rb ? byte_addr : '0;
  assign err_mismatch = mis_q;
`else
  assign busy         = (state_q == S_ACCEPT) | in_wr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ============================================================================
// Module   : tb_im_loader
// Purpose  : Self-checking bench for im_loader; one instance at base 0 and
//            one at base 252 share the same input stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start, instr_valid, instr_last;
  logic [31:0] instr_data;

  logic       rdy0, we0, busy0, done0, ovf0;
  logic [7:0] addr0, wd0;
  logic [6:0] cnt0;
  logic       rdyh, weh, busyh, doneh, ovfh;
  logic [7:0] addrh, wdh;
  logic [6:0] cnth;

`ifdef IM_LOADER_READBACK_EN
  localparam int WORD_CYC = 9;
  logic [7:0] raddr0, rdata0, raddrh, rdatah;
  logic       mis0, mish;
  logic       corrupt = 1'b0;
  logic [7:0] mem0 [256];
  logic [7:0] memh [256];
  assign rdata0 = mem0[raddr0] ^ ((corrupt && raddr0 == 8'd2) ? 8'h01 : 8'h00);
  assign rdatah = memh[raddrh];
  always @(posedge clk) begin
    if (we0) mem0[addr0] <= wd0;
    if (weh) memh[addrh] <= wdh;
  end
`else
  localparam int WORD_CYC = 5;
`endif

  im_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .instr_valid(instr_valid), .instr_ready(rdy0),
    .instr_data(instr_data), .instr_last(instr_last),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
`ifdef IM_LOADER_READBACK_EN
    .mem_raddr(raddr0), .mem_rdata(rdata0), .err_mismatch(mis0),
`endif
    .busy(busy0), .done(done0), .word_count(cnt0), .err_overflow(ovf0)
  );

  im_loader #(.ADDR_W(8), .BASE_ADDR(252)) dut_hi (
    .clk(clk), .reset(reset), .start(start),
    .instr_valid(instr_valid), .instr_ready(rdyh),
    .instr_data(instr_data), .instr_last(instr_last),
    .mem_we(weh), .mem_addr(addrh), .mem_wdata(wdh),
`ifdef IM_LOADER_READBACK_EN
    .mem_raddr(raddrh), .mem_rdata(rdatah), .err_mismatch(mish),
`endif
    .busy(busyh), .done(doneh), .word_count(cnth), .err_overflow(ovfh)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] a; logic [7:0] d; int c; } wr_t;
  wr_t cap0[$];
  wr_t caph[$];
  wr_t e0, eh;
  int  viol = 0;

  // Byte-write capture plus continuous protocol watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (we0) begin e0.a = addr0; e0.d = wd0; e0.c = cyc; cap0.push_back(e0); end
    if (weh) begin eh.a = addrh; eh.d = wdh; eh.c = cyc; caph.push_back(eh); end
    if (!we0 && (addr0 != 8'd0 || wd0 != 8'd0)) viol++;
    if (!weh && (addrh != 8'd0 || wdh != 8'd0)) viol++;
    if (rdy0 && (we0 || !busy0 || done0)) viol++;
    if (rdyh && (weh || !busyh || doneh)) viol++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] sess_w [16];
  int          sess_n;
  int          hs [16];
  int          st_cyc;

  task automatic send_word(input logic [31:0] d, input logic l, input int gap, output int hcyc);
    int t;
    repeat (gap) @(posedge clk);
    #1;
    instr_valid = 1'b1; instr_data = d; instr_last = l;
    t = 0;
    @(negedge clk);
    while (!rdy0 && t < 100) begin @(negedge clk); t++; end
    if (!rdy0) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    hcyc = cyc;
    instr_valid = 1'b0; instr_data = '0; instr_last = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!(done0 && doneh) && t < 200) begin @(negedge clk); t++; end
    check("done_timeout", {63'd0, done0 && doneh}, 64'd1);
  endtask

  // Reference: word i goes to base+4i, MSB first; the first word that would
  // pass address 255 is rejected and ends the session with the overflow flag.
  task automatic compare_session(input int base, input bit is_hi);
    wr_t   act[$];
    int    ea[$], ed[$], ec[$];
    int    words = 0;
    bit    ovf = 0;
    int    n;
    string tag;
    logic [9:0] act_st;
    for (int i = 0; i < sess_n; i++) begin
      if (base + 4*i > 256 - 4) begin ovf = 1; break; end
      for (int k = 0; k < 4; k++) begin
        ea.push_back(base + 4*i + k);
        ed.push_back(int'((sess_w[i] >> (24 - 8*k)) & 32'hFF));
        ec.push_back(hs[i] + k);
      end
      words++;
    end
    if (is_hi) begin act = caph; tag = "hi"; act_st = {cnth, doneh, busyh, ovfh}; end
    else       begin act = cap0; tag = "lo"; act_st = {cnt0, done0, busy0, ovf0}; end
    check({tag, "_nbytes"}, 64'(act.size()), 64'(ea.size()));
    n = (act.size() < ea.size()) ? act.size() : ea.size();
    for (int k = 0; k < n; k++)
      check({tag, "_byte"}, {act[k].a, act[k].d, act[k].c[15:0]},
            {8'(ea[k]), 8'(ed[k]), 16'(ec[k])});
    check({tag, "_status"}, 64'(act_st), 64'({7'(words), 1'b1, 1'b0, ovf}));
`ifdef IM_LOADER_READBACK_EN
    if (is_hi) check("hi_mismatch", {63'd0, mish}, 64'd0);
    else       check("lo_mismatch", {63'd0, mis0}, {63'd0, corrupt});
`endif
  endtask

  task automatic run_session(input int gap_lo, input int gap_hi, input bit vws);
    int g;
    cap0.delete(); caph.delete();
    @(posedge clk); #1;
    start = 1'b1;
    if (vws) begin instr_valid = 1'b1; instr_data = sess_w[0]; instr_last = (sess_n == 1); end
    @(posedge clk); #1;
    start = 1'b0;
    st_cyc = cyc;
    for (int i = 0; i < sess_n; i++) begin
      g = (i == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo));
      send_word(sess_w[i], i == sess_n - 1, g, hs[i]);
    end
    wait_done();
    check("accept_latency", 64'(hs[0]), 64'(st_cyc + 1));
    if (gap_hi == 0)
      for (int i = 1; i < sess_n; i++)
        check("word_period", 64'(hs[i] - hs[i-1]), 64'(WORD_CYC));
    compare_session(0, 1'b0);
    compare_session(252, 1'b1);
  endtask

  typedef struct { logic [31:0] word; logic [7:0] b0, b1, b2, b3; } vec_t;
  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] act_b;
    vecs[0] = '{32'hF84083E1, 8'hF8, 8'h40, 8'h83, 8'hE1};
    vecs[1] = '{32'h8B030022, 8'h8B, 8'h03, 8'h00, 8'h22};
    vecs[2] = '{32'hCB0400A6, 8'hCB, 8'h04, 8'h00, 8'hA6};
    vecs[3] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[5] = '{32'h0123ABCD, 8'h01, 8'h23, 8'hAB, 8'hCD};

    start = 1'b0; instr_valid = 1'b0; instr_last = 1'b0; instr_data = '0;
    #3 reset = 1'b1;
    #10;
    check("reset_state_lo", {rdy0, we0, addr0, wd0, busy0, done0, cnt0, ovf0}, 64'd0);
    check("reset_state_hi", {rdyh, weh, addrh, wdh, busyh, doneh, cnth, ovfh}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single-word sessions with hand-computed byte splits.
    for (int v = 0; v < 6; v++) begin
      sess_w[0] = vecs[v].word; sess_n = 1;
      run_session(0, 0, 1'b0);
      act_b = (cap0.size() == 4) ? {cap0[0].d, cap0[1].d, cap0[2].d, cap0[3].d} : 32'hDEADBEEF;
      check("vec_bytes", 64'(act_b), 64'({vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3}));
    end

    // Four words with ACCEPT held idle for three cycles between them.
    sess_w[0] = 32'h8B030022; sess_w[1] = 32'hCB0400A6;
    sess_w[2] = 32'hAA0800E9; sess_w[3] = 32'h8A0B014C; sess_n = 4;
    run_session(WORD_CYC + 2, WORD_CYC + 2, 1'b0);
    for (int i = 1; i < 4; i++)
      check("gap_period", 64'(hs[i] - hs[i-1]), 64'(WORD_CYC + 3));

    // Overflow: the high instance takes one word then rejects the next.
    sess_w[0] = 32'h11111111; sess_w[1] = 32'h22222222; sess_n = 2;
    run_session(0, 0, 1'b0);
    check("ovf_hi_bytes", 64'(caph.size()), 64'd4);
    check("ovf_hi_flags", {61'd0, ovfh, doneh, busyh}, 64'b110);

    // start together with valid: the word waits one cycle.
    sess_w[0] = 32'hA5A55A5A; sess_w[1] = 32'h3C3CC3C3; sess_n = 2;
    run_session(0, 0, 1'b1);

    // Async reset during WR2: two bytes written, everything cleared at once.
    cap0.delete(); caph.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    instr_valid = 1'b1; instr_data = 32'h11223344; instr_last = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0; instr_data = '0; instr_last = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("midreset_outputs", {rdy0, we0, addr0, wd0, busy0, done0, cnt0, ovf0}, 64'd0);
    check("midreset_nbytes", 64'(cap0.size()), 64'd2);
    if (cap0.size() >= 2)
      check("midreset_bytes", {cap0[0].a, cap0[0].d, cap0[1].a, cap0[1].d}, 64'h0011_0122);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_idle", {61'd0, busy0, done0, rdy0}, 64'd0);
    check("midreset_no_more", 64'(cap0.size()), 64'd2);
    sess_w[0] = 32'hF84083E1; sess_n = 1;
    run_session(0, 0, 1'b0);

`ifdef IM_LOADER_READBACK_EN
    corrupt = 1'b1;
    sess_w[0] = 32'hF84083E1; sess_n = 1;
    run_session(0, 0, 1'b0);
    corrupt = 1'b0;
    run_session(0, 0, 1'b0);
`endif

    // Randomized sessions against the reference model.
    for (int r = 0; r < 12; r++) begin
      sess_n = int'($urandom_range(6, 1));
      for (int i = 0; i < sess_n; i++) sess_w[i] = $urandom;
      run_session(0, int'($urandom_range(WORD_CYC + 3, 0)), 1'($urandom_range(1, 0)));
    end

    check("protocol_watch", 64'(viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
